// File: rtl/sprite_scheduler_if.sv
// rtl/sprite_scheduler_if.sv - engine handshake between the sprite scheduler and draw_sprite
interface sprite_scheduler_if #(
  parameter int X_W = 10
) ();
  logic           eng_start;
  logic [X_W-1:0] eng_x;
  logic [2:0]     eng_sprite;
  logic           eng_busy;

  modport master (output eng_start, output eng_x, output eng_sprite, input eng_busy);
  modport slave  (input eng_start, input eng_x, input eng_sprite, output eng_busy);
endinterface

// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - round-robin sharing of one draw_sprite engine among sprite slots
module sprite_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int ACK_TMO   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_frame_start,
  input  logic                     i_line_start,
  input  logic [Y_W-1:0]           i_pixel_y,
  input  logic [NUM_SLOTS-1:0]     i_slot_valid,
  input  logic [NUM_SLOTS*X_W-1:0] i_slot_x,
  input  logic [NUM_SLOTS*Y_W-1:0] i_slot_y,
  input  logic [NUM_SLOTS*3-1:0]   i_slot_sprite,
  sprite_scheduler_if.master       eng,
  output logic [NUM_SLOTS-1:0]     o_grant,
  output logic [NUM_SLOTS-1:0]     o_pending,
  output logic [NUM_SLOTS-1:0]     o_missed
);
  localparam int PTR_W = $clog2(NUM_SLOTS);
  localparam int TMR_W = $clog2(ACK_TMO + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} state_t;

  state_t               r_state, w_state_n;
  logic [NUM_SLOTS-1:0] r_grant, w_grant_n;
  logic [NUM_SLOTS-1:0] r_pending, w_pending_n;
  logic [NUM_SLOTS-1:0] r_missed, w_missed_n;
  logic [PTR_W-1:0]     r_rr_ptr, w_rr_ptr_n;
  logic [PTR_W-1:0]     r_win, w_win_n;
  logic [TMR_W-1:0]     r_timer, w_timer_n;
  logic [X_W-1:0]       r_eng_x, w_eng_x_n;
  logic [2:0]           r_eng_sprite, w_eng_sprite_n;
  logic                 w_eng_start;

  logic [X_W-1:0]       w_x   [NUM_SLOTS];
  logic [2:0]           w_spr [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_hits;
  logic [NUM_SLOTS-1:0] w_win_oh;
  logic                 w_found;
  logic [PTR_W-1:0]     w_win_idx;
  logic [PTR_W:0]       w_scan;
  logic [PTR_W:0]       w_rr_inc;

  always_comb begin
    w_hits = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_x[i]    = i_slot_x[i*X_W +: X_W];
      w_spr[i]  = i_slot_sprite[i*3 +: 3];
      w_hits[i] = i_line_start && r_pending[i] && (i_slot_y[i*Y_W +: Y_W] == i_pixel_y);
    end
  end

  // First hit at or after r_rr_ptr, wrapping around the slot range.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_scan    = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_scan >= (PTR_W+1)'(NUM_SLOTS))
        w_scan = w_scan - (PTR_W+1)'(NUM_SLOTS);
      if (!w_found && w_hits[w_scan[PTR_W-1:0]]) begin
        w_found   = 1'b1;
        w_win_idx = w_scan[PTR_W-1:0];
      end
    end
    w_win_oh            = '0;
    w_win_oh[w_win_idx] = 1'b1;
  end

  always_comb begin
    w_state_n      = r_state;
    w_grant_n      = r_grant;
    w_pending_n    = r_pending & i_slot_valid;
    w_missed_n     = r_missed;
    w_rr_ptr_n     = r_rr_ptr;
    w_win_n        = r_win;
    w_timer_n      = r_timer;
    w_eng_x_n      = r_eng_x;
    w_eng_sprite_n = r_eng_sprite;
    w_eng_start    = (r_state == S_ISSUE);
    w_rr_inc       = {1'b0, r_win} + (PTR_W+1)'(1);
    if (w_rr_inc >= (PTR_W+1)'(NUM_SLOTS))
      w_rr_inc = '0;

    if (i_frame_start) begin
      w_pending_n = i_slot_valid;
      w_missed_n  = '0;
      w_grant_n   = '0;
      w_state_n   = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_hits) begin
            w_pending_n = w_pending_n & ~w_hits;
            if (!eng.eng_busy) begin
              w_grant_n      = w_win_oh;
              w_win_n        = w_win_idx;
              w_eng_x_n      = w_x[w_win_idx];
              w_eng_sprite_n = w_spr[w_win_idx];
              w_missed_n     = r_missed | (w_hits & ~w_win_oh);
              w_state_n      = S_ISSUE;
            end else begin
              w_missed_n = r_missed | w_hits;
            end
          end
        end
        S_ISSUE: begin
          w_timer_n = '0;
          w_state_n = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (eng.eng_busy) begin
            w_state_n = S_WAIT_DONE;
          end else if (r_timer == TMR_W'(ACK_TMO - 1)) begin
            w_missed_n[r_win] = 1'b1;
            w_grant_n         = '0;
            w_state_n         = S_IDLE;
          end else begin
            w_timer_n = r_timer + TMR_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!eng.eng_busy) begin
            w_grant_n  = '0;
            w_rr_ptr_n = w_rr_inc[PTR_W-1:0];
            w_state_n  = S_IDLE;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
      // Engine already owned: anything matching this line cannot be drawn.
      if (r_state != S_IDLE) begin
        w_missed_n  = w_missed_n | w_hits;
        w_pending_n = w_pending_n & ~w_hits;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_pending    <= '0;
      r_missed     <= '0;
      r_rr_ptr     <= '0;
      r_win        <= '0;
      r_timer      <= '0;
      r_eng_x      <= '0;
      r_eng_sprite <= '0;
    end else begin
      r_state      <= w_state_n;
      r_grant      <= w_grant_n;
      r_pending    <= w_pending_n;
      r_missed     <= w_missed_n;
      r_rr_ptr     <= w_rr_ptr_n;
      r_win        <= w_win_n;
      r_timer      <= w_timer_n;
      r_eng_x      <= w_eng_x_n;
      r_eng_sprite <= w_eng_sprite_n;
    end
  end

  assign eng.eng_start  = w_eng_start;
  assign eng.eng_x      = r_eng_x;
  assign eng.eng_sprite = r_eng_sprite;
  assign o_grant        = r_grant;
  assign o_pending      = r_pending;
  assign o_missed       = r_missed;
endmodule

// File: tb/tb_sprite_scheduler.sv
// tb/tb_sprite_scheduler.sv - table-driven bench with start-pulse scoreboard for sprite_scheduler
module tb_sprite_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        fs, ls;
  logic [9:0]  py;
  logic [3:0]  valid;
  logic [39:0] sx, sy;
  logic [11:0] sspr;
  logic [3:0]  grant, pending, missed;

  always #5 clk = ~clk;

  sprite_scheduler_if #(.X_W(10)) ifc ();

  sprite_scheduler #(.NUM_SLOTS(4), .X_W(10), .Y_W(10), .ACK_TMO(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_frame_start (fs),
    .i_line_start  (ls),
    .i_pixel_y     (py),
    .i_slot_valid  (valid),
    .i_slot_x      (sx),
    .i_slot_y      (sy),
    .i_slot_sprite (sspr),
    .eng           (ifc),
    .o_grant       (grant),
    .o_pending     (pending),
    .o_missed      (missed)
  );

  localparam logic [39:0] SY_A = {10'd20, 10'd40, 10'd20, 10'd10};
  localparam logic [39:0] SY_B = {10'd20, 10'd40, 10'd20, 10'd20};
  localparam logic [39:0] SY_C = {10'd60, 10'd40, 10'd20, 10'd10};

  int slot_xv [4] = '{100, 200, 300, 400};
  int slot_sv [4] = '{1, 2, 3, 4};

  typedef struct {
    logic        fs;
    logic        ls;
    logic [9:0]  y;
    logic        busy;
    logic [3:0]  valid;
    logic [39:0] sy;
    logic        push;
    logic [3:0]  grant;
    logic [3:0]  pending;
    logic [3:0]  missed;
  } vec_t;

  typedef struct {
    logic [9:0] x;
    logic [2:0] spr;
    logic [3:0] g;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  sb_t  mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic f, input logic l, input logic [9:0] y, input logic b,
                              input logic [3:0] v, input logic [39:0] s, input logic p,
                              input logic [3:0] g, input logic [3:0] pd, input logic [3:0] m);
    vec_t r;
    r.fs = f; r.ls = l; r.y = y; r.busy = b; r.valid = v; r.sy = s; r.push = p;
    r.grant = g; r.pending = pd; r.missed = m;
    return r;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    sb_t e;
    fs = v.fs; ls = v.ls; py = v.y; ifc.eng_busy = v.busy; valid = v.valid; sy = v.sy;
    if (v.push) begin
      for (int i = 0; i < 4; i++) begin
        if (v.grant[i]) begin
          e.x   = 10'(slot_xv[i]);
          e.spr = 3'(slot_sv[i]);
          e.g   = v.grant;
        end
      end
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, "_grant"},   32'(grant),   32'(v.grant));
    chk({tag, "_pending"}, 32'(pending), 32'(v.pending));
    chk({tag, "_missed"},  32'(missed),  32'(v.missed));
    fs = 1'b0;
    ls = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ifc.eng_start === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("eng_start_unexpected", 32'(ifc.eng_start), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("start_eng_x",      32'(ifc.eng_x),      32'(mon_e.x));
        chk("start_eng_sprite", 32'(ifc.eng_sprite), 32'(mon_e.spr));
        chk("start_grant",      32'(grant),          32'(mon_e.g));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fs = 1'b0; ls = 1'b0; py = '0; valid = '0; sy = SY_A;
    sx   = {10'd400, 10'd300, 10'd200, 10'd100};
    sspr = {3'd4, 3'd3, 3'd2, 3'd1};
    ifc.eng_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant",      32'(grant),          32'd0);
    chk("rst_pending",    32'(pending),        32'd0);
    chk("rst_missed",     32'(missed),         32'd0);
    chk("rst_eng_start",  32'(ifc.eng_start),  32'd0);
    chk("rst_eng_x",      32'(ifc.eng_x),      32'd0);
    chk("rst_eng_sprite", 32'(ifc.eng_sprite), 32'd0);
    rst = 1'b0;

    // serve slot0, engine busy 3 cycles, then slot2 with rr_ptr=1
    vecs.push_back(mk(1, 0,  0, 0, 4'b0101, SY_A, 0, 4'b0000, 4'b0101, 4'b0000));
    vecs.push_back(mk(0, 1, 10, 0, 4'b0101, SY_A, 1, 4'b0001, 4'b0100, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 0, 4'b0101, SY_A, 0, 4'b0001, 4'b0100, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 1, 4'b0101, SY_A, 0, 4'b0001, 4'b0100, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 1, 4'b0101, SY_A, 0, 4'b0001, 4'b0100, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 1, 4'b0101, SY_A, 0, 4'b0001, 4'b0100, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 0, 4'b0101, SY_A, 0, 4'b0000, 4'b0100, 4'b0000));
    vecs.push_back(mk(0, 1, 40, 0, 4'b0101, SY_A, 1, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 0, 4'b0101, SY_A, 0, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 1, 4'b0101, SY_A, 0, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 0, 4'b0101, SY_A, 0, 4'b0000, 4'b0000, 4'b0000));
    // bring rr_ptr to 1 by serving slot0 alone
    vecs.push_back(mk(1, 0,  0, 0, 4'b0001, SY_A, 0, 4'b0000, 4'b0001, 4'b0000));
    vecs.push_back(mk(0, 1, 10, 0, 4'b0001, SY_A, 1, 4'b0001, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 0, 4'b0001, SY_A, 0, 4'b0001, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 1, 4'b0001, SY_A, 0, 4'b0001, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 0, 4'b0001, SY_A, 0, 4'b0000, 4'b0000, 4'b0000));
    // three-way collision on line 20 with rr_ptr=1
    vecs.push_back(mk(1, 0,  0, 0, 4'b1011, SY_B, 0, 4'b0000, 4'b1011, 4'b0000));
    vecs.push_back(mk(0, 1, 20, 0, 4'b1011, SY_B, 1, 4'b0010, 4'b0000, 4'b1001));
    vecs.push_back(mk(0, 0,  0, 0, 4'b1011, SY_B, 0, 4'b0010, 4'b0000, 4'b1001));
    vecs.push_back(mk(0, 0,  0, 1, 4'b1011, SY_B, 0, 4'b0010, 4'b0000, 4'b1001));
    vecs.push_back(mk(0, 0,  0, 0, 4'b1011, SY_B, 0, 4'b0000, 4'b0000, 4'b1001));
    vecs.push_back(mk(1, 0,  0, 0, 4'b1011, SY_B, 0, 4'b0000, 4'b1011, 4'b0000));
    // invalid slot drops pending and does not regain it; foreign busy misses all hits
    vecs.push_back(mk(0, 0,  0, 0, 4'b0011, SY_B, 0, 4'b0000, 4'b0011, 4'b0000));
    vecs.push_back(mk(0, 0,  0, 0, 4'b1011, SY_B, 0, 4'b0000, 4'b0011, 4'b0000));
    vecs.push_back(mk(0, 1, 20, 1, 4'b1011, SY_B, 0, 4'b0000, 4'b0000, 4'b0011));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("v%0d", i));

    chk("hold_eng_x",      32'(ifc.eng_x),      32'd200);
    chk("hold_eng_sprite", 32'(ifc.eng_sprite), 32'd2);

    // acknowledge timeout: busy never rises
    apply(mk(1, 0,  0, 0, 4'b0001, SY_A, 0, 4'b0000, 4'b0001, 4'b0000), "tmo_fs");
    apply(mk(0, 1, 10, 0, 4'b0001, SY_A, 1, 4'b0001, 4'b0000, 4'b0000), "tmo_ls");
    apply(mk(0, 0,  0, 0, 4'b0001, SY_A, 0, 4'b0001, 4'b0000, 4'b0000), "tmo_issue");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 0, 0, 4'b0001, SY_A, 0, 4'b0001, 4'b0000, 4'b0000), $sformatf("tmo_wait%0d", i));
    apply(mk(0, 0,  0, 0, 4'b0001, SY_A, 0, 4'b0000, 4'b0000, 4'b0001), "tmo_expire");

    // line hit while engine drawing, then frame abort during WAIT_DONE
    apply(mk(1, 0,  0, 0, 4'b1100, SY_C, 0, 4'b0000, 4'b1100, 4'b0000), "occ_fs");
    apply(mk(0, 1, 40, 0, 4'b1100, SY_C, 1, 4'b0100, 4'b1000, 4'b0000), "occ_ls40");
    apply(mk(0, 0,  0, 0, 4'b1100, SY_C, 0, 4'b0100, 4'b1000, 4'b0000), "occ_issue");
    apply(mk(0, 0,  0, 1, 4'b1100, SY_C, 0, 4'b0100, 4'b1000, 4'b0000), "occ_ack");
    apply(mk(0, 1, 60, 1, 4'b1100, SY_C, 0, 4'b0100, 4'b0000, 4'b1000), "occ_ls60");
    apply(mk(0, 0,  0, 1, 4'b1100, SY_C, 0, 4'b0100, 4'b0000, 4'b1000), "occ_hold");
    apply(mk(1, 0,  0, 1, 4'b1100, SY_C, 0, 4'b0000, 4'b1100, 4'b0000), "occ_abort");
    apply(mk(0, 0,  0, 0, 4'b1100, SY_C, 0, 4'b0000, 4'b1100, 4'b0000), "occ_idle");

    // coincident frame_start and line_start, then reset mid WAIT_ACK
    apply(mk(1, 1, 40, 0, 4'b1100, SY_C, 0, 4'b0000, 4'b1100, 4'b0000), "coin_fsls");
    apply(mk(0, 0,  0, 0, 4'b1100, SY_C, 0, 4'b0000, 4'b1100, 4'b0000), "coin_after");
    apply(mk(0, 1, 40, 0, 4'b1100, SY_C, 1, 4'b0100, 4'b1000, 4'b0000), "rst_ls");
    apply(mk(0, 0,  0, 0, 4'b1100, SY_C, 0, 4'b0100, 4'b1000, 4'b0000), "rst_issue");
    #2;
    rst = 1'b1;
    #1;
    chk("async_grant",      32'(grant),          32'd0);
    chk("async_pending",    32'(pending),        32'd0);
    chk("async_missed",     32'(missed),         32'd0);
    chk("async_eng_start",  32'(ifc.eng_start),  32'd0);
    chk("async_eng_x",      32'(ifc.eng_x),      32'd0);
    chk("async_eng_sprite", 32'(ifc.eng_sprite), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("scoreboard_drain", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
